// File: rtl/adma_dm_aw_sched.sv
// Write-address scheduler: round-robin arbitration of per-channel write
// requests onto one AXI AW channel, with a {channel, AWID} record pushed to
// the B-response tracker for every issued burst. It also enforces per-channel
// and global outstanding-write limits.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | searching for an eligible channel; a grant latches the payload
// ISSUE | AW and tracker record pending; back to IDLE once both have handshaken
module adma_dm_aw_sched #(
    parameter int  DMA_CHN_NUM   = 4,
    parameter int  MST_ID_W      = 5,
    parameter int  ADDR_W        = 32,
    parameter int  LEN_W         = 8,
    parameter int  ATX_NUM_OSTD  = DMA_CHN_NUM,
    parameter int  CHN_OSTD_MAX  = 2,
    localparam int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        chn_awaddr   [0:DMA_CHN_NUM-1],
    input  logic [LEN_W-1:0]         chn_awlen    [0:DMA_CHN_NUM-1],
    input  logic                     chn_req_vld  [0:DMA_CHN_NUM-1],
    output logic                     chn_req_rdy  [0:DMA_CHN_NUM-1],
    input  logic                     chn_done     [0:DMA_CHN_NUM-1],
    output logic [3:0]               chn_ostd_cnt [0:DMA_CHN_NUM-1],
    output logic                     ostd_err,
    output logic [MST_ID_W-1:0]      m_awid_o,
    output logic [ADDR_W-1:0]        m_awaddr_o,
    output logic [LEN_W-1:0]         m_awlen_o,
    output logic                     m_awvalid_o,
    input  logic                     m_awready_i,
    output logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
    output logic [MST_ID_W-1:0]      atx_awid,
    output logic                     atx_vld,
    input  logic                     atx_rdy
);

    localparam int TOT_W = $clog2(ATX_NUM_OSTD + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                   state_q, state_d;
    logic [DMA_CHN_NUM_W-1:0] rr_ptr_q, rr_ptr_d;
    logic                     aw_pend_q, aw_pend_d;
    logic                     atx_pend_q, atx_pend_d;
    logic [MST_ID_W-1:0]      awid_q, awid_d;
    logic [ADDR_W-1:0]        awaddr_q, awaddr_d;
    logic [LEN_W-1:0]         awlen_q, awlen_d;
    logic [DMA_CHN_NUM_W-1:0] chn_id_q, chn_id_d;
    logic [3:0]               cnt_q [0:DMA_CHN_NUM-1];
    logic [3:0]               cnt_d [0:DMA_CHN_NUM-1];
    logic [TOT_W-1:0]         total_q, total_d;
    logic                     err_q, err_d;

    logic                     elig [0:DMA_CHN_NUM-1];
    logic                     grant_vld;
    logic [DMA_CHN_NUM_W-1:0] grant_idx;

    function automatic int rr_idx(input int ptr, input int ofs);
        return (ptr + ofs) % DMA_CHN_NUM;
    endfunction

    // Eligibility from registered counters and round-robin winner search from rr_ptr
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int c = 0; c < DMA_CHN_NUM; c++) begin
            elig[c] = chn_req_vld[c] && (cnt_q[c] < 4'(CHN_OSTD_MAX)) &&
                      (total_q < TOT_W'(ATX_NUM_OSTD));
        end
        for (int i = 0; i < DMA_CHN_NUM; i++) begin
            if (!grant_vld && elig[rr_idx(int'(rr_ptr_q), i)]) begin
                grant_vld = (state_q == IDLE);
                grant_idx = DMA_CHN_NUM_W'(rr_idx(int'(rr_ptr_q), i));
            end
        end
    end

    // Grant pulse; held low while reset is asserted so no request is accepted into a cleared scheduler
    always_comb begin
        for (int c = 0; c < DMA_CHN_NUM; c++) begin
            chn_req_rdy[c] = rst_n && grant_vld && (grant_idx == DMA_CHN_NUM_W'(c));
        end
    end

    // FSM next state, pending flags, payload latch and round-robin pointer
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        aw_pend_d  = aw_pend_q;
        atx_pend_d = atx_pend_q;
        awid_d     = awid_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        chn_id_d   = chn_id_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    awid_d                   = '0;
                    awid_d[DMA_CHN_NUM_W-1:0] = grant_idx;
                    awaddr_d   = chn_awaddr[grant_idx];
                    awlen_d    = chn_awlen[grant_idx];
                    chn_id_d   = grant_idx;
                    aw_pend_d  = 1'b1;
                    atx_pend_d = 1'b1;
                    state_d    = ISSUE;
                    rr_ptr_d   = (int'(grant_idx) == DMA_CHN_NUM - 1) ? '0 : grant_idx + 1'b1;
                end
            end
            ISSUE: begin
                if (aw_pend_q && m_awready_i) aw_pend_d = 1'b0;
                if (atx_pend_q && atx_rdy)    atx_pend_d = 1'b0;
                if (!aw_pend_d && !atx_pend_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outstanding counters: reserve at grant, release on done; done on an empty channel only flags an error
    always_comb begin
        total_d = total_q + TOT_W'(grant_vld);
        err_d   = err_q;
        for (int c = 0; c < DMA_CHN_NUM; c++) begin
            cnt_d[c] = cnt_q[c];
            if (grant_vld && (grant_idx == DMA_CHN_NUM_W'(c))) cnt_d[c] = cnt_d[c] + 4'd1;
            if (chn_done[c]) begin
                if (cnt_q[c] != 4'd0) begin
                    cnt_d[c] = cnt_d[c] - 4'd1;
                    total_d  = total_d - TOT_W'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            aw_pend_q  <= 1'b0;
            atx_pend_q <= 1'b0;
            awid_q     <= '0;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            chn_id_q   <= '0;
            total_q    <= '0;
            err_q      <= 1'b0;
            for (int c = 0; c < DMA_CHN_NUM; c++) cnt_q[c] <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            aw_pend_q  <= aw_pend_d;
            atx_pend_q <= atx_pend_d;
            awid_q     <= awid_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
            chn_id_q   <= chn_id_d;
            total_q    <= total_d;
            err_q      <= err_d;
            for (int c = 0; c < DMA_CHN_NUM; c++) cnt_q[c] <= cnt_d[c];
        end
    end

    assign m_awvalid_o  = aw_pend_q;
    assign m_awid_o     = awid_q;
    assign m_awaddr_o   = awaddr_q;
    assign m_awlen_o    = awlen_q;
    assign atx_vld      = atx_pend_q;
    assign atx_chn_id   = chn_id_q;
    assign atx_awid     = awid_q;
    assign chn_ostd_cnt = cnt_q;
    assign ostd_err     = err_q;

endmodule
